// File: rtl/user_io_adder.sv
// -----------------------------------------------------------------------------
// user_io_adder
//
// Wishbone-mapped adder peripheral for the Caravel user project area.
// Firmware writes an 8-bit operand A (OPA).
// A 2-bit operand B arrives on mprj_io[3:2] and is synchronised before use.
// The 9-bit sum is kept in RESULT, and its low two bits drive mprj_io[1:0].
// mprj_io[4] is an external clear pin.
//
// Optional feature: define ADD_OVF_IRQ_EN to enable the sticky overflow flag.
// The flag is STATUS bit3 and is cleared by writing 1 to it (W1C).
// With the flag enabled, user_irq = OVF & CTRL.en.
// Without ADD_OVF_IRQ_EN, STATUS bit3 reads 0 and user_irq is held at 0.
//
// Register map (offset = wbs_adr_i[3:2]):
//   0x0 CTRL    RW  bit0 en (reset 1)
//   0x4 OPA     RW  [7:0]
//   0x8 RESULT  RO  [8:0]
//   0xC STATUS  RO  [2:0] = {clr_s, B_s}, bit3 = OVF (W1C)
//
// Ports:
//   wb_clk_i   system clock, all logic on the rising edge
//   wb_rst_i   synchronous active-high reset
//   wbs_*      Wishbone slave: cyc, stb, we, sel[3:0], adr[31:0], dat_i[31:0],
//              ack_o, dat_o[31:0]
//   io_in[4:0]  pad inputs: [4] clr, [3:2] operand B, [1:0] unused
//   io_out[4:0] pad outputs: [1:0] sum[1:0], [4:2] tied 0
//   io_oeb[4:0] output enables (active low), constant 5'b11100
//   user_irq    overflow interrupt
// -----------------------------------------------------------------------------
module user_io_adder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [4:0]  io_in,
    output logic [4:0]  io_out,
    output logic [4:0]  io_oeb,
    output logic        user_irq
);

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_OPA    = 2'd1;
    localparam logic [1:0] OFS_RESULT = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    // Two-stage synchroniser for the pins {clr, B[1:0]}.
    logic [2:0]  sync1_r;
    logic [2:0]  sync2_r;
    logic        clr_s;
    logic [1:0]  b_s;

    logic        ctrl_en_r;
    logic [7:0]  opa_r;
    logic [8:0]  result_r;
    logic [1:0]  io_out_r;
    logic        ack_r;
    logic [31:0] dat_r;
    logic        ovf_r;
    logic        irq_r;

    logic        hit_s;
    logic        accept_s;
    logic        wr_s;
    logic        w1c_s;
    logic [31:0] rd_data_s;
    logic        ctrl_en_nxt_s;
    logic [7:0]  opa_nxt_s;
    logic [8:0]  result_nxt_s;
    logic [1:0]  io_out_nxt_s;
    logic        ovf_nxt_s;
    logic        unused_s;

    assign clr_s = sync2_r[2];
    assign b_s   = sync2_r[1:0];

    // Bits with no function in this peripheral; the XOR only collects them.
    assign unused_s = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i, io_in};

    // Wishbone decode.
    // The access is accepted only when no ack is pending, so a held
    // request is acknowledged every other cycle.
    always_comb begin
        hit_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        accept_s = hit_s & ~ack_r;
        wr_s     = accept_s & wbs_we_i;
        w1c_s    = 1'b0;
        if (wr_s && (wbs_adr_i[3:2] == OFS_STATUS) && wbs_sel_i[0]) begin
            w1c_s = wbs_dat_i[3];
        end else begin
            w1c_s = 1'b0;
        end
    end

    // Next values of the register file and the datapath.
    // The sum uses the current opa_r, so an OPA write in the same cycle is
    // seen by the adder one cycle later.
    always_comb begin
        ctrl_en_nxt_s = ctrl_en_r;
        opa_nxt_s     = opa_r;
        if (wr_s && (wbs_adr_i[3:2] == OFS_CTRL) && wbs_sel_i[0]) begin
            ctrl_en_nxt_s = wbs_dat_i[0];
        end else begin
            ctrl_en_nxt_s = ctrl_en_r;
        end
        if (wr_s && (wbs_adr_i[3:2] == OFS_OPA) && wbs_sel_i[0]) begin
            opa_nxt_s = wbs_dat_i[7:0];
        end else begin
            opa_nxt_s = opa_r;
        end
        if (clr_s) begin
            result_nxt_s = 9'd0;
            io_out_nxt_s = 2'b00;
        end else begin
            result_nxt_s = {1'b0, opa_r} + {7'd0, b_s};
            io_out_nxt_s = ctrl_en_r ? result_r[1:0] : 2'b00;
        end
`ifdef ADD_OVF_IRQ_EN
        // A set in the same cycle as a W1C clear wins.
        ovf_nxt_s = result_nxt_s[8] | (ovf_r & ~w1c_s);
`else
        ovf_nxt_s = 1'b0;
`endif
    end

    // Read data multiplexer.
    always_comb begin
        rd_data_s = 32'd0;
        case (wbs_adr_i[3:2])
            OFS_CTRL:   rd_data_s = {31'd0, ctrl_en_r};
            OFS_OPA:    rd_data_s = {24'd0, opa_r};
            OFS_RESULT: rd_data_s = {23'd0, result_r};
            OFS_STATUS: rd_data_s = {28'd0, ovf_r, clr_s, b_s};
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Pin synchroniser.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= io_in[4:2];
            sync2_r <= sync1_r;
        end
    end

    // Register file, datapath, output register and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_en_r <= 1'b1;
            opa_r     <= 8'h00;
            result_r  <= 9'd0;
            io_out_r  <= 2'b00;
            ovf_r     <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            ctrl_en_r <= ctrl_en_nxt_s;
            opa_r     <= opa_nxt_s;
            result_r  <= result_nxt_s;
            io_out_r  <= io_out_nxt_s;
            ovf_r     <= ovf_nxt_s;
            irq_r     <= ovf_nxt_s & ctrl_en_nxt_s;
        end
    end

    // Wishbone response.
    // The ack lasts one cycle. Read data is driven only while ack is high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= accept_s;
            if (accept_s && !wbs_we_i) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= 32'd0;
            end
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign io_out    = {3'b000, io_out_r};
    assign io_oeb    = 5'b11100;
    assign user_irq  = irq_r;

endmodule

// File: tb/tb_user_io_adder.sv
module tb_user_io_adder;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat_o;
    logic [4:0]  io_in;
    logic [4:0]  io_out;
    logic [4:0]  io_oeb;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    user_io_adder #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat_o),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .user_irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One Wishbone access.
    // The request is raised at a negedge.
    // ack is sampled 1 ns after each rising edge, for at most 6 edges.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic acked, output logic [31:0] rd,
                           output int lat, output logic dropped);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; rd = 32'd0; lat = 0; dropped = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (!acked) begin
                @(posedge clk); #1;
                if (ack) begin
                    acked = 1'b1; rd = rdat_o; lat = i;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (acked) begin
            @(posedge clk); #1;
            dropped = ~ack;
        end
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd, output logic acked);
        int l; logic dr;
        wb_xfer(1'b0, a, 32'd0, 4'b1111, acked, rd, l, dr);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic acked);
        int l; logic dr; logic [31:0] rd;
        wb_xfer(1'b1, a, d, s, acked, rd, l, dr);
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic ak;
        rst = 1'b1; io_in = 5'b00000;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        n_cmp++; if (io_out !== 5'b00000) begin n_fail++; $display("FAIL reset_io_out got %b want 00000", io_out); end
        n_cmp++; if (io_oeb !== 5'b11100) begin n_fail++; $display("FAIL reset_io_oeb got %b want 11100", io_oeb); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        wb_rd(BASE + 32'h0, rd, ak);
        n_cmp++; if (ak !== 1'b1 || rd !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl got %h ack %b want 00000001", rd, ak); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (ak !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h ack %b want 00000000", rd, ak); end
    endtask

    task automatic test_clear_release;
        logic [31:0] rd; logic ak; int lat;
        @(negedge clk); io_in = 5'b11000;   // clr=1, B=10
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (io_out !== 5'b00000) begin n_fail++; $display("FAIL clr_io_out got %b want 00000", io_out); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL clr_result got %h want 00000000", rd); end
        @(negedge clk); io_in = 5'b01000;   // release clr
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (lat == 0 && io_out[1:0] == 2'b10) lat = i;
        end
        n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL release_latency got %0d want 4", lat); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL release_result got %h want 00000002", rd); end
    endtask

    task automatic test_opa_write;
        logic [31:0] rd; logic ak; int lat; logic dr;
        wb_xfer(1'b1, BASE + 32'h4, 32'h05, 4'b0001, ak, rd, lat, dr);
        n_cmp++; if (ak !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL opa_ack_latency got %0d ack %b want 1", lat, ak); end
        n_cmp++; if (dr !== 1'b1) begin n_fail++; $display("FAIL opa_ack_single got held want single cycle"); end
        @(posedge clk); #1;
        n_cmp++; if (io_out[1:0] !== 2'b11) begin n_fail++; $display("FAIL opa_io_out got %b want 11", io_out[1:0]); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL opa_result got %h want 00000007", rd); end
        wb_rd(BASE + 32'h4, rd, ak);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL opa_readback got %h want 00000005", rd); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] pat; logic bad;
        pat = 6'd0; bad = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
            if (rdat_o !== (ack ? 32'h5 : 32'h0)) bad = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (pat !== 6'b010101) begin n_fail++; $display("FAIL b2b_ack_pattern got %b want 010101", pat); end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL b2b_dat_o got bad data want 5 on ack else 0"); end
    endtask

    task automatic test_overflow;
        logic [31:0] rd; logic ak; logic [31:0] exp_st; logic exp_irq;
`ifdef ADD_OVF_IRQ_EN
        exp_st = 32'h9; exp_irq = 1'b1;
`else
        exp_st = 32'h1; exp_irq = 1'b0;
`endif
        @(negedge clk); io_in = 5'b00100;   // B=01
        wb_wr(BASE + 32'h4, 32'hFF, 4'b0001, ak);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (io_out[1:0] !== 2'b00) begin n_fail++; $display("FAIL ovf_io_out got %b want 00", io_out[1:0]); end
        n_cmp++; if (irq !== exp_irq) begin n_fail++; $display("FAIL ovf_irq got %b want %b", irq, exp_irq); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h100) begin n_fail++; $display("FAIL ovf_result got %h want 00000100", rd); end
        wb_rd(BASE + 32'hC, rd, ak);
        n_cmp++; if (rd !== exp_st) begin n_fail++; $display("FAIL ovf_status got %h want %h", rd, exp_st); end
        // Remove the overflow condition; the sticky flag must hold until W1C.
        wb_wr(BASE + 32'h4, 32'h00, 4'b0001, ak);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (irq !== exp_irq) begin n_fail++; $display("FAIL ovf_sticky_irq got %b want %b", irq, exp_irq); end
        wb_wr(BASE + 32'hC, 32'h8, 4'b0001, ak);
        wb_rd(BASE + 32'hC, rd, ak);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL w1c_status got %h want 00000001", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b want 0", irq); end
    endtask

    task automatic test_ctrl_disable;
        logic [31:0] rd; logic ak;
        @(negedge clk); io_in = 5'b01000;   // B=10
        wb_wr(BASE + 32'h4, 32'h05, 4'b0001, ak);
        repeat (5) @(posedge clk);
        wb_wr(BASE + 32'h0, 32'h0, 4'b0001, ak);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (io_out[1:0] !== 2'b00) begin n_fail++; $display("FAIL dis_io_out got %b want 00", io_out[1:0]); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL dis_result got %h want 00000007", rd); end
        @(negedge clk); io_in = 5'b00100;   // B=01
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (io_out[1:0] !== 2'b00) begin n_fail++; $display("FAIL dis_io_out2 got %b want 00", io_out[1:0]); end
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h6) begin n_fail++; $display("FAIL dis_track got %h want 00000006", rd); end
        @(negedge clk); io_in = 5'b10100;   // clr=1
        repeat (5) @(posedge clk);
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midclr_result got %h want 00000000", rd); end
        wb_rd(BASE + 32'h4, rd, ak);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL midclr_opa got %h want 00000005", rd); end
        wb_rd(BASE + 32'h0, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midclr_ctrl got %h want 00000000", rd); end
        @(negedge clk); io_in = 5'b00100;   // release clr, B=01
        wb_wr(BASE + 32'h0, 32'h1, 4'b0001, ak);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (io_out[1:0] !== 2'b10) begin n_fail++; $display("FAIL reen_io_out got %b want 10", io_out[1:0]); end
    endtask

    task automatic test_decode;
        logic [31:0] rd; logic ak;
        wb_rd(BASE + 32'h10, rd, ak);
        n_cmp++; if (ak !== 1'b0) begin n_fail++; $display("FAIL miss_ack got %b want 0", ak); end
        wb_wr(BASE + 32'h4, 32'hAA, 4'b0000, ak);
        n_cmp++; if (ak !== 1'b1) begin n_fail++; $display("FAIL sel0_ack got %b want 1", ak); end
        wb_rd(BASE + 32'h4, rd, ak);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL sel0_opa got %h want 00000005", rd); end
        wb_wr(BASE + 32'h0, 32'h0, 4'b0000, ak);
        wb_rd(BASE + 32'h0, rd, ak);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL sel0_ctrl got %h want 00000001", rd); end
        wb_wr(BASE + 32'h8, 32'h1FF, 4'b1111, ak);
        wb_rd(BASE + 32'h8, rd, ak);
        n_cmp++; if (rd !== 32'h6) begin n_fail++; $display("FAIL ro_result got %h want 00000006", rd); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic ak; logic seen;
        seen = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h4; wdat = 32'h33; sel = 4'b0001;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        if (ack) seen = 1'b1;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_ack got 1 want 0"); end
        wb_rd(BASE + 32'h4, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_opa got %h want 00000000", rd); end
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'b0000;
        adr = 32'd0; wdat = 32'd0; io_in = 5'b00000;
        test_reset();
        test_clear_release();
        test_opa_write();
        test_back_to_back();
        test_overflow();
        test_ctrl_disable();
        test_decode();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
